// File: rtl/key_debounce_sync.sv
// Conditions active-low KEY pins: synchronise, debounce with a stability counter, invert.
// key_level feeds the PIO in_port; key_press/key_release are one-cycle fabric pulses.
module key_debounce_sync #(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_raw_n,
  output logic [WIDTH-1:0] key_level,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release
);

  localparam logic [1:0] RELEASED        = 2'd0;
  localparam logic [1:0] PRESS_PENDING   = 2'd1;
  localparam logic [1:0] PRESSED         = 2'd2;
  localparam logic [1:0] RELEASE_PENDING = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  for (genvar g = 0; g < WIDTH; g++) begin : g_key
    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0]             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    logic                   press_q;
    logic                   rel_q;
    logic                   s;

    // Synchroniser resets to all-ones so the key starts out released.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_q <= '1;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw_n[g]};
      end
    end

    assign s = ~sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= RELEASED;
        cnt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        case (state_q)
          RELEASED: begin
            level_q <= 1'b0;
            cnt_q   <= '0;
            if (s) begin
              state_q <= PRESS_PENDING;
              cnt_q   <= CNT_ONE;
            end
          end
          PRESS_PENDING: begin
            if (!s) begin
              state_q <= RELEASED;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= PRESSED;
              cnt_q   <= '0;
              level_q <= 1'b1;
              press_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          PRESSED: begin
            level_q <= 1'b1;
            cnt_q   <= '0;
            if (!s) begin
              state_q <= RELEASE_PENDING;
              cnt_q   <= CNT_ONE;
            end
          end
          RELEASE_PENDING: begin
            if (s) begin
              state_q <= PRESSED;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= RELEASED;
              cnt_q   <= '0;
              level_q <= 1'b0;
              rel_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end
        endcase
      end
    end

    assign key_level[g]   = level_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = rel_q;
  end

endmodule
